// File: rtl/expand_1s_pkg.sv
// Shared types and constants for the 1s-run expander (expand_1s_fsm).
// The optional stretch counter is enabled with the EXPAND_1S_STRETCH_CNT_EN macro.
package expand_1s_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      HOLD = 2'b10
   } state_t;

   localparam int unsigned MAX_EXTEND    = 255;
   localparam int unsigned STRETCH_CNT_W = 8;

   // Saturating increment used by the stretch statistics counter.
   function automatic logic [STRETCH_CNT_W-1:0] sat_inc(input logic [STRETCH_CNT_W-1:0] v);
      return (v == {STRETCH_CNT_W{1'b1}}) ? v : v + STRETCH_CNT_W'(1);
   endfunction

endpackage

// File: rtl/expand_tail_cnt.sv
// Loadable down-counter tracking how many forced-1 tail samples remain.
// last flags the final tail sample so the FSM can leave HOLD without underflow.
module expand_tail_cnt #(
   parameter int unsigned CW = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          dec,
   input  logic [CW-1:0] load_val,
   output logic [CW-1:0] cnt,
   output logic          last
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: load wins over decrement, otherwise hold.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec) begin
         cnt_d = cnt_q - CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {CW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign last = (cnt_q == CW'(1));

endmodule

// File: rtl/expand_1s_fsm.sv
// Mealy expander: stretches each run of 1s by EXTEND trailing valid samples.
// Define EXPAND_1S_STRETCH_CNT_EN to add the saturating stretch_cnt statistics port.
module expand_1s_fsm
   import expand_1s_pkg::*;
#(
   parameter int unsigned EXTEND = 1,
   localparam int unsigned CW = ($clog2(EXTEND + 1) > 1) ? $clog2(EXTEND + 1) : 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_valid,
   input  logic in,
   output logic out_valid,
   output logic out
`ifdef EXPAND_1S_STRETCH_CNT_EN
   ,
   output logic [STRETCH_CNT_W-1:0] stretch_cnt
`endif
);

   // RUN->HOLD loads EXTEND-1 because the run-ending sample is itself the first tail sample.
   localparam logic [CW-1:0] TAIL_LOAD = CW'((EXTEND >= 32'd2) ? (EXTEND - 32'd1) : 32'd0);

   state_t        state_q;
   state_t        state_d;
   logic          out_s;
   logic          tail_load_s;
   logic          tail_dec_s;
   logic [CW-1:0] tail_val_s;
   logic [CW-1:0] tail_cnt_s;
   logic          tail_last_s;

   expand_tail_cnt #(
      .CW(CW)
   ) u_tail_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tail_load_s),
      .dec      (tail_dec_s),
      .load_val (tail_val_s),
      .cnt      (tail_cnt_s),
      .last     (tail_last_s)
   );

   // Next-state, tail-counter control and Mealy output; invalid samples change nothing.
   always_comb begin
      state_d     = state_q;
      out_s       = 1'b0;
      tail_load_s = 1'b0;
      tail_dec_s  = 1'b0;
      tail_val_s  = TAIL_LOAD;
      if (in_valid) begin
         case (state_q)
            IDLE: begin
               out_s   = in;
               state_d = in ? RUN : IDLE;
            end
            RUN: begin
               if (in) begin
                  out_s   = 1'b1;
                  state_d = RUN;
               end else if (EXTEND == 32'd0) begin
                  out_s   = 1'b0;
                  state_d = IDLE;
               end else if (EXTEND == 32'd1) begin
                  out_s   = 1'b1;
                  state_d = IDLE;
               end else begin
                  out_s       = 1'b1;
                  tail_load_s = 1'b1;
                  tail_val_s  = TAIL_LOAD;
                  state_d     = HOLD;
               end
            end
            HOLD: begin
               out_s = 1'b1;
               if (in) begin
                  state_d = RUN;
               // A zero count here is unreachable; treating it as the last sample keeps HOLD from wrapping.
               end else if (tail_last_s || (tail_cnt_s == {CW{1'b0}})) begin
                  state_d     = IDLE;
                  tail_load_s = 1'b1;
                  tail_val_s  = {CW{1'b0}};
               end else begin
                  tail_dec_s = 1'b1;
                  state_d    = HOLD;
               end
            end
            default: begin
               out_s   = in;
               state_d = IDLE;
            end
         endcase
      end else begin
         out_s = 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign out_valid = in_valid;
   assign out       = out_s;

`ifdef EXPAND_1S_STRETCH_CNT_EN
   logic [STRETCH_CNT_W-1:0] stretch_cnt_q;

   // Counts valid samples where a 0 input was forced to 1, saturating at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stretch_cnt_q <= {STRETCH_CNT_W{1'b0}};
      end else if (in_valid && out_s && !in) begin
         stretch_cnt_q <= sat_inc(stretch_cnt_q);
      end else begin
         stretch_cnt_q <= stretch_cnt_q;
      end
   end

   assign stretch_cnt = stretch_cnt_q;
`endif

endmodule

// File: tb/tb_expand_1s_fsm.sv
// Scoreboard bench: four expanders (EXTEND=0..3) share one stimulus stream and are
// compared against a remaining-tail model; stretch_cnt is checked when the macro is on.
module tb_expand_1s_fsm;

   logic clk;
   logic rst_n;
   logic in_valid;
   logic in;

   logic       ov_w [4];
   logic       o_w  [4];
   logic [1:0] st_w [4];
   logic [7:0] sc_w [4];

   int tests_run;
   int tests_failed;

   typedef struct packed {
      logic       ov;
      logic [3:0] o;
      logic [7:0] st;
      logic [7:0] sc;
   } exp_t;

   exp_t sb_q[$];

   int   rem   [4];
   logic last1 [4];
   int   ext   [4];
   int   sc_m;
   int   n_step;

`ifdef EXPAND_1S_STRETCH_CNT_EN
   expand_1s_fsm #(.EXTEND(0)) u_e0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in),
      .out_valid(ov_w[0]), .out(o_w[0]), .stretch_cnt(sc_w[0]));
   expand_1s_fsm #(.EXTEND(1)) u_e1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in),
      .out_valid(ov_w[1]), .out(o_w[1]), .stretch_cnt(sc_w[1]));
   expand_1s_fsm #(.EXTEND(2)) u_e2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in),
      .out_valid(ov_w[2]), .out(o_w[2]), .stretch_cnt(sc_w[2]));
   expand_1s_fsm #(.EXTEND(3)) u_e3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in),
      .out_valid(ov_w[3]), .out(o_w[3]), .stretch_cnt(sc_w[3]));
`else
   expand_1s_fsm #(.EXTEND(0)) u_e0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in),
      .out_valid(ov_w[0]), .out(o_w[0]));
   expand_1s_fsm #(.EXTEND(1)) u_e1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in),
      .out_valid(ov_w[1]), .out(o_w[1]));
   expand_1s_fsm #(.EXTEND(2)) u_e2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in),
      .out_valid(ov_w[2]), .out(o_w[2]));
   expand_1s_fsm #(.EXTEND(3)) u_e3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in),
      .out_valid(ov_w[3]), .out(o_w[3]));
   assign sc_w[0] = 8'd0;
   assign sc_w[1] = 8'd0;
   assign sc_w[2] = 8'd0;
   assign sc_w[3] = 8'd0;
`endif

   assign st_w[0] = u_e0.state_q;
   assign st_w[1] = u_e1.state_q;
   assign st_w[2] = u_e2.state_q;
   assign st_w[3] = u_e3.state_q;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         rem[k]   = 0;
         last1[k] = 1'b0;
      end
      sc_m = 0;
   endtask

   // Pop the oldest expectation and compare every DUT against it.
   task automatic compare_out();
      exp_t e;
      if (sb_q.size() == 0) begin
         check_val("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         for (int k = 0; k < 4; k++) begin
            check_val($sformatf("ov_e%0d@%0d", k, n_step), {31'd0, ov_w[k]}, {31'd0, e.ov});
            check_val($sformatf("out_e%0d@%0d", k, n_step), {31'd0, o_w[k]}, {31'd0, e.o[k]});
            check_val($sformatf("st_e%0d@%0d", k, n_step), {30'd0, st_w[k]}, {30'd0, e.st[2*k +: 2]});
         end
`ifdef EXPAND_1S_STRETCH_CNT_EN
         check_val($sformatf("stretch@%0d", n_step), {24'd0, sc_w[2]}, {24'd0, e.sc});
`endif
      end
   endtask

   task automatic step(input logic v, input logic d);
      exp_t e;
      @(negedge clk);
      in_valid = v;
      in       = d;
      e        = '0;
      e.ov     = v;
      for (int k = 0; k < 4; k++) begin
         e.st[2*k +: 2] = last1[k] ? 2'b01 : ((rem[k] > 0) ? 2'b10 : 2'b00);
         if (!v)      e.o[k] = 1'b0;
         else if (d)  e.o[k] = 1'b1;
         else         e.o[k] = (rem[k] > 0);
      end
      e.sc = sc_m[7:0];
      sb_q.push_back(e);
      #1;
      compare_out();
      n_step++;
      if (v) begin
         for (int k = 0; k < 4; k++) begin
            if (d) begin
               rem[k]   = ext[k];
               last1[k] = 1'b1;
            end else begin
               if (rem[k] > 0) rem[k] = rem[k] - 1;
               last1[k] = 1'b0;
            end
         end
         if (!d && e.o[2] && sc_m < 255) sc_m++;
      end
   endtask

   task automatic flush();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      n_step       = 0;
      ext          = '{0, 1, 2, 3};
      rst_n        = 1'b0;
      in_valid     = 1'b0;
      in           = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         check_val($sformatf("rst_st_e%0d", k), {30'd0, st_w[k]}, 32'd0);
         check_val($sformatf("rst_out_e%0d", k), {31'd0, o_w[k]}, 32'd0);
      end
      check_val("rst_stretch", {24'd0, sc_w[2]}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed sequences from the test plan, separated by zero flushes.
      step(1, 0); step(1, 1); step(1, 1); step(1, 1); step(1, 0); step(1, 0);
      flush();
      step(1, 1); step(1, 0); step(1, 0); step(1, 0); step(1, 0); step(1, 0);
      flush();
      step(1, 1); step(1, 0); step(1, 1); step(1, 0); step(1, 0); step(1, 0); step(1, 0);
      flush();
      step(1, 1); step(0, 1); step(0, 0); step(1, 0); step(1, 0); step(1, 0);
      flush();
      step(1, 1); step(1, 0); step(1, 1); step(1, 1); step(1, 0);
      flush();

      // Asynchronous reset in the middle of the EXTEND=3 tail.
      step(1, 1); step(1, 0);
      @(posedge clk);
      #2;
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in       = 1'b1;
      #1;
      model_reset();
      for (int k = 0; k < 4; k++) begin
         check_val($sformatf("mid_rst_st_e%0d", k), {30'd0, st_w[k]}, 32'd0);
         check_val($sformatf("mid_rst_out_e%0d", k), {31'd0, o_w[k]}, 32'd1);
      end
      check_val("mid_rst_stretch", {24'd0, sc_w[2]}, 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 0);

      // Stretch counting: one run, then enough runs to saturate.
      step(1, 1); step(1, 0); step(1, 0); step(1, 0);
      for (int i = 0; i < 150; i++) begin
         step(1, 1); step(1, 0); step(1, 0);
      end
      step(1, 0);

      // Random traffic with gaps.
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0);
      end
      step(1, 0);

      check_val("sb_drained", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
